qcpu_mem_arbiter: RTL and testbench

- Arbitrates one shared single-port memory bus between two requesters inside tt_um_quick_cpu:
  - requester 0: host loader, driven from the ui_in / uio_in pins;
  - requester 1: CPU instruction/data port.
- Round-robin grant, one outstanding transaction at a time, variable-latency memory acknowledge, watchdog timeout.
- Sits between the CPU core, the pin-facing loader and the memory macro; gated by `ena`.

---
 rtl/qcpu_mem_arbiter_pkg.sv | 22 ++
 rtl/qcpu_mem_arbiter_if.sv | 32 +++
 rtl/qcpu_mem_arbiter_rr_pick.sv | 24 ++
 rtl/qcpu_mem_arbiter.sv | 140 ++++++++++++++
 tb/tb_qcpu_mem_arbiter.sv | 303 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/qcpu_mem_arbiter_pkg.sv
// qcpu_pkg: constants and types shared by the memory arbiter and the CPU core.
//   - default address/data widths and memory watchdog limit
//   - requester indices (host loader, CPU port)
//   - arbiter FSM state encoding
package qcpu_pkg;

  localparam int QCPU_AW      = 8;
  localparam int QCPU_DW      = 8;
  localparam int QCPU_TIMEOUT = 15;
  localparam int QCPU_TW      = 4;

  localparam int   NUM_REQ  = 2;
  localparam logic REQ_HOST = 1'b0;
  localparam logic REQ_CPU  = 1'b1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } arb_state_e;

endpackage

// File: rtl/qcpu_mem_arbiter_if.sv
// qcpu_mem_arbiter_if: single-port memory bus between the arbiter and the
// memory macro.
//   master (arbiter): drives mem_req/mem_we/mem_addr/mem_wdata,
//                     receives mem_ack/mem_rdata
//   slave  (memory) : the mirror image
// mem_req is held until mem_ack or a watchdog abort; mem_rdata is only
// meaningful in the mem_ack cycle.
interface qcpu_mem_arbiter_if
  import qcpu_pkg::*;
#(
  parameter int AW = QCPU_AW,
  parameter int DW = QCPU_DW
) ();

  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_ack;
  logic [DW-1:0] mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_ack, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_ack, mem_rdata
  );

endinterface

// File: rtl/qcpu_mem_arbiter_rr_pick.sv
// qcpu_rr_pick: 2-way combinational round-robin selector.
//   req_i  : per-requester request
//   last_i : index granted most recently
//   idx_o  : winning requester index
//   vld_o  : at least one requester is asking
// On a tie the requester that was not granted last wins; otherwise the sole
// requester wins.
module qcpu_rr_pick
  import qcpu_pkg::*;
(
  input  logic [NUM_REQ-1:0] req_i,
  input  logic               last_i,
  output logic               idx_o,
  output logic               vld_o
);

  always_comb begin
    vld_o = |req_i;
    // Sole requester (or don't-care when nobody asks).
    idx_o = req_i[REQ_CPU];
    if (&req_i) idx_o = ~last_i;
  end

endmodule

// File: rtl/qcpu_mem_arbiter.sv
// qcpu_mem_arbiter: shares one single-port memory bus between the host
// loader (requester 0) and the CPU port (requester 1).
//   clk, rst_n        : clock, async active-low reset
//   ena_i             : enable; low blocks new grants only
//   req_i / we_i      : per-requester request (held until done) / write enable
//   addr0_i, addr1_i  : requester addresses
//   wdata0_i, wdata1_i: requester write data
//   done_o / err_o    : one-cycle completion / watchdog-abort pulse
//   rdata_o           : read data, valid in the done cycle
//   busy_o            : transaction in flight (grant through ack/abort)
//   mem               : memory bus, master side
// One transaction at a time: IDLE -> ACCESS (wait for ack or watchdog)
// -> RESP (done pulse) -> IDLE. All outputs are registered.
module qcpu_mem_arbiter
  import qcpu_pkg::*;
#(
  parameter int AW      = QCPU_AW,
  parameter int DW      = QCPU_DW,
  parameter int TIMEOUT = QCPU_TIMEOUT,
  parameter int TW      = QCPU_TW
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                ena_i,
  input  logic [NUM_REQ-1:0]  req_i,
  input  logic [NUM_REQ-1:0]  we_i,
  input  logic [AW-1:0]       addr0_i,
  input  logic [AW-1:0]       addr1_i,
  input  logic [DW-1:0]       wdata0_i,
  input  logic [DW-1:0]       wdata1_i,
  output logic [NUM_REQ-1:0]  done_o,
  output logic [NUM_REQ-1:0]  err_o,
  output logic [DW-1:0]       rdata_o,
  output logic                busy_o,
  qcpu_mem_arbiter_if.master  mem
);

  // Last ACCESS cycle before the watchdog fires: the counter runs
  // 0..TIMEOUT-1, giving TIMEOUT ACCESS cycles in total.
  localparam logic [TW-1:0] CNT_LAST = TW'(TIMEOUT - 1);

  arb_state_e                       state_q;
  logic                             last_q;
  logic                             win_q;
  logic [TW-1:0]                    cnt_q, cnt_d;
  logic                             mem_req_q, mem_we_q;
  logic [AW-1:0]                    mem_addr_q;
  logic [DW-1:0]                    mem_wdata_q;
  logic [DW-1:0]                    rdata_q;
  logic                             busy_q;
  logic [NUM_REQ-1:0]               done_q, err_q;

  logic [NUM_REQ-1:0][AW-1:0]       addr_v;
  logic [NUM_REQ-1:0][DW-1:0]       wdata_v;
  logic                             pick_idx, pick_vld;

  assign addr_v  = {addr1_i, addr0_i};
  assign wdata_v = {wdata1_i, wdata0_i};
  assign cnt_d   = cnt_q + TW'(1);

  qcpu_rr_pick u_pick (
    .req_i  (req_i),
    .last_i (last_q),
    .idx_o  (pick_idx),
    .vld_o  (pick_vld)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      last_q      <= REQ_CPU;   // host wins the first tie
      win_q       <= REQ_HOST;
      cnt_q       <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      rdata_q     <= '0;
      busy_q      <= 1'b0;
      done_q      <= '0;
      err_q       <= '0;
    end else begin
      // Completion pulses last exactly one cycle (the RESP cycle).
      done_q <= '0;
      err_q  <= '0;
      case (state_q)
        IDLE: begin
          if (ena_i && pick_vld) begin
            win_q       <= pick_idx;
            last_q      <= pick_idx;
            cnt_q       <= '0;
            mem_req_q   <= 1'b1;
            mem_we_q    <= we_i[pick_idx];
            mem_addr_q  <= addr_v[pick_idx];
            mem_wdata_q <= wdata_v[pick_idx];
            busy_q      <= 1'b1;
            state_q     <= ACCESS;
          end
        end
        ACCESS: begin
          // Ack is tested first so an ack on the final count still wins.
          if (mem.mem_ack) begin
            if (!mem_we_q) rdata_q <= mem.mem_rdata;
            mem_req_q     <= 1'b0;
            mem_we_q      <= 1'b0;
            busy_q        <= 1'b0;
            done_q[win_q] <= 1'b1;
            state_q       <= RESP;
          end else if (cnt_q == CNT_LAST) begin
            rdata_q       <= '0;
            mem_req_q     <= 1'b0;
            mem_we_q      <= 1'b0;
            busy_q        <= 1'b0;
            done_q[win_q] <= 1'b1;
            err_q[win_q]  <= 1'b1;
            state_q       <= RESP;
          end else begin
            cnt_q <= cnt_d;
          end
        end
        RESP: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign mem.mem_req   = mem_req_q;
  assign mem.mem_we    = mem_we_q;
  assign mem.mem_addr  = mem_addr_q;
  assign mem.mem_wdata = mem_wdata_q;
  assign done_o        = done_q;
  assign err_o         = err_q;
  assign rdata_o       = rdata_q;
  assign busy_o        = busy_q;

endmodule

// File: tb/tb_qcpu_mem_arbiter.sv
// tb_qcpu_mem_arbiter: scoreboard bench for qcpu_mem_arbiter.
// Expected transactions are queued when a request is driven; the monitor
// checks the grant on the mem_req rising edge and pops/compares on done.
module tb_qcpu_mem_arbiter;
  import qcpu_pkg::*;

  localparam int AW = 8, DW = 8, TIMEOUT = 15, TW = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          ena = 1'b0;
  logic [1:0]    req = '0, we = '0;
  logic [AW-1:0] addr0 = '0, addr1 = '0;
  logic [DW-1:0] wdata0 = '0, wdata1 = '0;
  logic [1:0]    done, err;
  logic [DW-1:0] rdata;
  logic          busy;

  qcpu_mem_arbiter_if #(.AW(AW), .DW(DW)) mbus ();

  qcpu_mem_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(TIMEOUT), .TW(TW)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .ena_i    (ena),
    .req_i    (req),
    .we_i     (we),
    .addr0_i  (addr0),
    .addr1_i  (addr1),
    .wdata0_i (wdata0),
    .wdata1_i (wdata1),
    .done_o   (done),
    .err_o    (err),
    .rdata_o  (rdata),
    .busy_o   (busy),
    .mem      (mbus.master)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       idx;
    logic       we;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic [7:0] rdata;
    logic       err;
  } exp_t;

  exp_t       sb_q[$];
  exp_t       mon_e;
  logic [7:0] mem_arr [256];
  logic [7:0] model_rdata = '0;
  int         ack_dly = 0;
  int         n_chk = 0, n_err = 0;
  int         last_len = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, act, exp);
    end
  endtask

  function automatic logic [1:0] onehot(input logic i);
    logic [1:0] v;
    v    = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  // Queue one expected transaction; the local memory array doubles as the
  // reference for read data.
  task automatic push(input logic i, input logic w, input logic [7:0] a,
                      input logic [7:0] d, input int dly);
    exp_t e;
    e.idx = i; e.we = w; e.addr = a; e.wdata = d;
    e.err = (dly >= TIMEOUT);
    if (e.err)  e.rdata = 8'h00;
    else if (w) begin e.rdata = model_rdata; mem_arr[a] = d; end
    else        e.rdata = mem_arr[a];
    model_rdata = e.rdata;
    sb_q.push_back(e);
  endtask

  task automatic issue(input logic i, input logic w, input logic [7:0] a, input logic [7:0] d);
    if (i) begin addr1 = a; wdata1 = d; end
    else   begin addr0 = a; wdata0 = d; end
    we[i]  = w;
    req[i] = 1'b1;
  endtask

  // i < 0 waits for either requester.
  task automatic wait_done(input int i, output int cyc);
    cyc = 0;
    while (cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (i < 0 ? (done != 2'b00) : done[i]) return;
    end
    chk("wait_done_bound", 32'd0, 32'd1);
  endtask

  // Memory model: acks in the (ack_dly+1)-th ACCESS cycle.
  initial begin
    int cnt;
    cnt = 0;
    mbus.mem_ack   = 1'b0;
    mbus.mem_rdata = '0;
    forever begin
      @(negedge clk);
      if (mbus.mem_req && !mbus.mem_ack) begin
        if (cnt == ack_dly) begin
          mbus.mem_ack   = 1'b1;
          mbus.mem_rdata = mem_arr[mbus.mem_addr];
          cnt = 0;
        end else begin
          cnt++;
        end
      end else begin
        mbus.mem_ack = 1'b0;
        cnt = 0;
      end
    end
  end

  // Monitor: grant contents on mem_req rise, completion on done.
  initial begin
    logic prev;
    int   len;
    prev = 1'b0;
    len  = 0;
    forever begin
      @(negedge clk);
      if (mbus.mem_req) begin
        if (!prev) begin
          len = 0;
          if (sb_q.size() == 0) chk("grant_unexpected", 32'd1, 32'd0);
          else begin
            chk("gnt_addr", 32'(mbus.mem_addr), 32'(sb_q[0].addr));
            chk("gnt_we", 32'(mbus.mem_we), 32'(sb_q[0].we));
            if (sb_q[0].we) chk("gnt_wdata", 32'(mbus.mem_wdata), 32'(sb_q[0].wdata));
          end
        end
        len++;
      end else if (prev) begin
        last_len = len;
      end
      prev = mbus.mem_req;
      if ((err & ~done) != 2'b00) chk("err_without_done", 32'(err), 32'(err & done));
      if (done != 2'b00) begin
        if (sb_q.size() == 0) chk("done_unexpected", 32'(done), 32'd0);
        else begin
          mon_e = sb_q.pop_front();
          chk("done", 32'(done), 32'(onehot(mon_e.idx)));
          chk("err", 32'(err), mon_e.err ? 32'(onehot(mon_e.idx)) : 32'd0);
          chk("rdata", 32'(rdata), 32'(mon_e.rdata));
          chk("busy_in_resp", 32'(busy), 32'd0);
        end
      end
    end
  end

  initial begin
    int cyc, left0, left1, k;
    logic i;
    for (int a = 0; a < 256; a++) mem_arr[a] = 8'(a * 7 + 3);
    mem_arr[8'h12] = 8'hA5;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_mem_req", 32'(mbus.mem_req), 32'd0);
    chk("rst_mem_we", 32'(mbus.mem_we), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_rdata", 32'(rdata), 32'd0);
    chk("rst_mem_addr", 32'(mbus.mem_addr), 32'd0);
    chk("rst_mem_wdata", 32'(mbus.mem_wdata), 32'd0);
    rst_n = 1'b1;
    ena   = 1'b1;
    @(negedge clk);

    // Contention: both held, each drops for one cycle after its done.
    ack_dly = 0;
    push(1'b0, 1'b0, 8'h10, 8'h00, 0);
    push(1'b1, 1'b0, 8'h20, 8'h00, 0);
    push(1'b0, 1'b0, 8'h11, 8'h00, 0);
    push(1'b1, 1'b0, 8'h21, 8'h00, 0);
    issue(1'b0, 1'b0, 8'h10, 8'h00);
    issue(1'b1, 1'b0, 8'h20, 8'h00);
    left0 = 1; left1 = 1;
    for (k = 0; k < 4; k++) begin
      wait_done(-1, cyc);
      i = done[1];
      req[i] = 1'b0;
      @(negedge clk);
      if (!i && left0 > 0) begin issue(1'b0, 1'b0, 8'h11, 8'h00); left0--; end
      if (i && left1 > 0)  begin issue(1'b1, 1'b0, 8'h21, 8'h00); left1--; end
    end
    repeat (2) @(negedge clk);

    // Single read: 1-cycle grant latency, ack after 2 wait cycles.
    ack_dly = 2;
    chk("rd_idle_mem_req", 32'(mbus.mem_req), 32'd0);
    push(1'b0, 1'b0, 8'h12, 8'h00, 2);
    issue(1'b0, 1'b0, 8'h12, 8'h00);
    @(negedge clk);
    chk("rd_grant_latency", 32'(mbus.mem_req), 32'd1);
    wait_done(0, cyc);
    chk("rd_total_cycles", 32'(cyc + 1), 32'd4);
    req = '0;
    @(negedge clk);

    // Write from the CPU port; rdata must keep 0xA5.
    ack_dly = 1;
    push(1'b1, 1'b1, 8'h40, 8'h3C, 1);
    issue(1'b1, 1'b1, 8'h40, 8'h3C);
    wait_done(1, cyc);
    req = '0; we = '0;
    @(negedge clk);

    // Watchdog abort.
    ack_dly = 1000;
    push(1'b0, 1'b0, 8'h33, 8'h00, 1000);
    issue(1'b0, 1'b0, 8'h33, 8'h00);
    wait_done(0, cyc);
    chk("to_total_cycles", 32'(cyc), 32'(TIMEOUT + 1));
    req = '0;
    @(negedge clk);
    chk("to_mem_req_len", 32'(last_len), 32'(TIMEOUT));

    // Ack on the final count wins over the watchdog.
    ack_dly = TIMEOUT - 1;
    push(1'b1, 1'b0, 8'h55, 8'h00, TIMEOUT - 1);
    issue(1'b1, 1'b0, 8'h55, 8'h00);
    wait_done(1, cyc);
    req = '0;
    @(negedge clk);

    // ena low blocks grants; raising it grants on the next cycle.
    ena = 1'b0;
    ack_dly = 0;
    push(1'b0, 1'b0, 8'h07, 8'h00, 0);
    issue(1'b0, 1'b0, 8'h07, 8'h00);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      chk("ena_low_no_grant", 32'(mbus.mem_req), 32'd0);
    end
    ena = 1'b1;
    @(negedge clk);
    chk("ena_high_grant", 32'(mbus.mem_req), 32'd1);
    wait_done(0, cyc);
    req = '0;
    @(negedge clk);

    // ena dropped mid-transaction: transaction still completes.
    ack_dly = 3;
    push(1'b1, 1'b0, 8'h08, 8'h00, 3);
    issue(1'b1, 1'b0, 8'h08, 8'h00);
    repeat (2) @(negedge clk);
    ena = 1'b0;
    wait_done(1, cyc);
    req = '0;
    ena = 1'b1;
    @(negedge clk);

    // Reset during ACCESS: immediate clear, no done.
    ack_dly = 1000;
    push(1'b0, 1'b0, 8'h21, 8'h00, 1000);
    issue(1'b0, 1'b0, 8'h21, 8'h00);
    repeat (3) @(negedge clk);
    chk("pre_rst_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_mem_req", 32'(mbus.mem_req), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    sb_q.delete();
    model_rdata = 8'h00;
    req = '0;
    repeat (2) @(negedge clk);
    chk("mid_rst_no_done", 32'(done), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // After reset the host wins a tie.
    ack_dly = 0;
    push(1'b0, 1'b0, 8'h30, 8'h00, 0);
    push(1'b1, 1'b0, 8'h31, 8'h00, 0);
    issue(1'b0, 1'b0, 8'h30, 8'h00);
    issue(1'b1, 1'b0, 8'h31, 8'h00);
    wait_done(0, cyc);
    req[0] = 1'b0;
    wait_done(1, cyc);
    req[1] = 1'b0;
    repeat (3) @(negedge clk);
    chk("sb_empty", 32'(sb_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
